// File: rtl/vga_fb_sched.sv
// Framebuffer scheduler: prefetches each scan line from video RAM into a ping-pong
// line buffer, serves pixels from the other bank, and hands idle RAM cycles to a CPU write port.
module vga_fb_sched #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vga_valid,
    input  logic [9:0]        vga_h_addr,
    input  logic [9:0]        vga_v_addr,
    input  logic              vga_vsync,
    output logic [23:0]       vga_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [23:0]       mem_wdata,
    input  logic [23:0]       mem_rdata,
    input  logic              cpu_wvalid,
    output logic              cpu_wready,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [23:0]       cpu_wdata,
    output logic              fetch_busy,
    output logic              underrun
);
    localparam int                XW          = $clog2(H_ACTIVE);
    localparam int                FB_WORDS    = H_ACTIVE * V_ACTIVE;
    localparam logic [XW-1:0]     X_LAST      = XW'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W:0]   FB_LIMIT    = (ADDR_W + 1)'(FB_WORDS);
    localparam logic [10:0]       V_LIMIT     = 11'(V_ACTIVE);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t            state_reg, state_next;
    logic              vsync_q_reg, valid_q_reg;
    logic [XW-1:0]     x_reg;
    logic              bank_reg;
    logic [ADDR_W-1:0] base_reg;
    logic              rd_pending_reg;
    logic              rd_bank_reg;
    logic [XW-1:0]     rd_x_reg;
    logic              underrun_reg;

    logic              frame_trig;
    logic              line_trig;
    logic              trigger;
    logic              new_bank;
    logic [10:0]       next_y;
    logic              handshake;
    logic              in_range;

    // Trigger detection; a frame start overrides a coincident line start.
    always_comb begin
        next_y     = {1'b0, vga_v_addr} + 11'd1;
        frame_trig = vga_vsync && !vsync_q_reg;
        line_trig  = vga_valid && !valid_q_reg && (next_y < V_LIMIT);
        trigger    = frame_trig || line_trig;
        new_bank   = frame_trig ? 1'b0 : next_y[0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (trigger) state_next = FETCH;
            end
            FETCH: begin
                if (trigger)              state_next = FETCH;
                else if (x_reg == X_LAST) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_reg      <= IDLE;
            vsync_q_reg    <= 1'b0;
            valid_q_reg    <= 1'b0;
            x_reg          <= '0;
            bank_reg       <= 1'b0;
            base_reg       <= '0;
            rd_pending_reg <= 1'b0;
            rd_bank_reg    <= 1'b0;
            rd_x_reg       <= '0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            vsync_q_reg <= vga_vsync;
            valid_q_reg <= vga_valid;
            // The read issued this cycle always lands, even if a restart follows.
            rd_pending_reg <= (state_reg == FETCH);
            rd_bank_reg    <= bank_reg;
            rd_x_reg       <= x_reg;
            if (trigger) begin
                x_reg    <= '0;
                bank_reg <= new_bank;
                base_reg <= frame_trig ? '0 : base_reg + LINE_STRIDE;
                if (state_reg == FETCH) underrun_reg <= 1'b1;
            end else if (state_reg == FETCH) begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

    logic [23:0] bank_rd [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic [23:0] line_mem [H_ACTIVE];
            always_ff @(posedge pclk) begin
                if (rd_pending_reg && (rd_bank_reg == 1'(gi)))
                    line_mem[rd_x_reg] <= mem_rdata;
            end
            assign bank_rd[gi] = line_mem[vga_h_addr[XW-1:0]];
        end
    endgenerate

    assign vga_data   = vga_valid ? bank_rd[vga_v_addr[0]] : 24'h0;

    assign fetch_busy = (state_reg == FETCH);
    assign mem_ren    = fetch_busy;
    assign cpu_wready = !reset && (state_reg == IDLE);
    assign handshake  = cpu_wvalid && cpu_wready;
    // Writes beyond the visible framebuffer complete the handshake but never reach RAM.
    assign in_range   = ({1'b0, cpu_waddr} < FB_LIMIT);
    assign mem_wen    = handshake && in_range;
    assign mem_wdata  = mem_wen ? cpu_wdata : 24'h0;
    assign mem_addr   = fetch_busy ? (base_reg + ADDR_W'(x_reg))
                                   : (mem_wen ? cpu_waddr : '0);
    assign underrun   = underrun_reg;

endmodule

// File: tb/tb_vga_fb_sched.sv
// Directed bench for vga_fb_sched: a RAM model, a cycle-level behavioural model of the
// fetch schedule and line buffers, and literal spot checks at the scenario boundaries.
module tb_vga_fb_sched;
    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AW = 19;

    logic          pclk = 1'b0;
    logic          reset;
    logic          vga_valid;
    logic [9:0]    vga_h_addr;
    logic [9:0]    vga_v_addr;
    logic          vga_vsync;
    logic [23:0]   vga_data;
    logic [AW-1:0] mem_addr;
    logic          mem_ren;
    logic          mem_wen;
    logic [23:0]   mem_wdata;
    logic [23:0]   mem_rdata;
    logic          cpu_wvalid;
    logic          cpu_wready;
    logic [AW-1:0] cpu_waddr;
    logic [23:0]   cpu_wdata;
    logic          fetch_busy;
    logic          underrun;

    always #5 pclk = ~pclk;

    vga_fb_sched #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .pclk(pclk), .reset(reset),
        .vga_valid(vga_valid), .vga_h_addr(vga_h_addr), .vga_v_addr(vga_v_addr),
        .vga_vsync(vga_vsync), .vga_data(vga_data),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_wvalid(cpu_wvalid), .cpu_wready(cpu_wready),
        .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .fetch_busy(fetch_busy), .underrun(underrun)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    logic [23:0] ram [int];
    logic [23:0] rdata_next;

    // Model: a fetch is "the 640 reads following a trigger cycle", unless superseded.
    logic        m_fetching, m_underrun, m_vsq, m_vq, m_pend, m_pbank, m_fbank;
    int          m_start, m_base, m_fbase, m_px;
    logic [23:0] m_pdata;
    logic [23:0] m_lb [2][H];
    bit          m_known [2][H];

    function automatic logic [23:0] ram_init(int a);
        return 24'((a * 389) ^ 32'h5A5A5A);
    endfunction

    function automatic logic [23:0] ram_rd(int a);
        if (ram.exists(a)) return ram[a];
        return ram_init(a);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        int   idx, y, hx, e_addr;
        logic e_ren, e_rdy, e_wen, frame_t, line_t;
        idx    = cyc - m_start;
        e_ren  = m_fetching;
        e_rdy  = !reset && !m_fetching;
        e_wen  = cpu_wvalid && e_rdy && (int'(cpu_waddr) < H * V);
        e_addr = e_ren ? m_fbase + idx : int'(cpu_waddr);
        y      = int'(vga_v_addr);
        hx     = int'(vga_h_addr);

        check("mem_ren",    32'(mem_ren),    32'(e_ren));
        check("fetch_busy", 32'(fetch_busy), 32'(e_ren));
        check("cpu_wready", 32'(cpu_wready), 32'(e_rdy));
        check("mem_wen",    32'(mem_wen),    32'(e_wen));
        check("underrun",   32'(underrun),   32'(m_underrun));
        if (e_ren && mem_wen) check("ren_wen_overlap", 32'(mem_wen), 32'(0));
        if (e_ren || e_wen) check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_wen) check("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
        if (!vga_valid) check("vga_blank", 32'(vga_data), 32'(0));
        else if (m_known[y % 2][hx]) check("vga_data", 32'(vga_data), 32'(m_lb[y % 2][hx]));

        // RAM behaviour, driven by the strobes the DUT actually presents.
        rdata_next = mem_ren ? ram_rd(int'(mem_addr)) : 24'h0;
        if (mem_wen) ram[int'(mem_addr)] = mem_wdata;

        // Advance to the next cycle.
        if (m_pend) begin
            m_lb[m_pbank][m_px]    = m_pdata;
            m_known[m_pbank][m_px] = 1'b1;
        end
        m_pend  = e_ren;
        m_pbank = m_fbank;
        m_px    = idx;
        m_pdata = ram_rd(e_addr);
        if (e_ren && idx == H - 1) m_fetching = 1'b0;
        if (reset) begin
            m_fetching = 1'b0; m_underrun = 1'b0; m_vsq = 1'b0; m_vq = 1'b0;
            m_pend = 1'b0; m_base = 0;
        end else begin
            frame_t = vga_vsync && !m_vsq;
            line_t  = vga_valid && !m_vq && (y + 1 < V);
            if (frame_t || line_t) begin
                if (e_ren) m_underrun = 1'b1;
                m_base     = frame_t ? 0 : m_base + H;
                m_fbase    = m_base;
                m_fbank    = frame_t ? 1'b0 : 1'((y + 1) % 2);
                m_fetching = 1'b1;
                m_start    = cyc + 1;
            end
            m_vsq = vga_vsync;
            m_vq  = vga_valid;
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge pclk);
        model_cycle();
    endtask

    task automatic advance();
        @(posedge pclk);
        #2;
        mem_rdata = rdata_next;
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            sample();
            advance();
        end
    endtask

    initial begin
        reset = 1'b1; vga_valid = 1'b0; vga_h_addr = '0; vga_v_addr = '0; vga_vsync = 1'b0;
        cpu_wvalid = 1'b0; cpu_waddr = '0; cpu_wdata = '0; mem_rdata = '0; rdata_next = '0;
        m_fetching = 1'b0; m_underrun = 1'b0; m_vsq = 1'b0; m_vq = 1'b0; m_pend = 1'b0;
        m_pbank = 1'b0; m_fbank = 1'b0; m_start = 0; m_base = 0; m_fbase = 0; m_px = 0;
        m_pdata = '0;
        @(posedge pclk);
        #2;
        tick(2);
        sample();
        check("rst_wready",   32'(cpu_wready), 32'(0));
        check("rst_busy",     32'(fetch_busy), 32'(0));
        check("rst_underrun", 32'(underrun),   32'(0));
        advance();
        reset = 1'b0;
        sample();
        check("idle_wready", 32'(cpu_wready), 32'(1));
        advance();

        // Back-to-back CPU writes while idle, then one beyond the framebuffer.
        for (int i = 0; i < 4; i++) begin
            cpu_wvalid = 1'b1; cpu_waddr = 19'(100000 + i); cpu_wdata = 24'(24'h100 + i);
            tick();
        end
        cpu_waddr = 19'd307200; cpu_wdata = 24'h777777;
        sample();
        check("oob_ready", 32'(cpu_wready), 32'(1));
        check("oob_wen",   32'(mem_wen),    32'(0));
        advance();
        cpu_wvalid = 1'b0;
        tick(3);

        // Frame start: line 0 into bank 0, CPU stalled throughout.
        vga_vsync = 1'b1;
        sample();
        check("trig_cycle_ren", 32'(mem_ren), 32'(0));
        advance();
        sample();
        check("first_ren",  32'(mem_ren),    32'(1));
        check("first_addr", 32'(mem_addr),   32'(0));
        check("first_busy", 32'(fetch_busy), 32'(1));
        advance();
        cpu_wvalid = 1'b1; cpu_waddr = 19'd5; cpu_wdata = 24'hABCDEF;
        tick(638);
        sample();
        check("last_addr",    32'(mem_addr),   32'(639));
        check("stall_wready", 32'(cpu_wready), 32'(0));
        advance();
        sample();
        check("hs_wready", 32'(cpu_wready), 32'(1));
        check("hs_wen",    32'(mem_wen),    32'(1));
        check("hs_addr",   32'(mem_addr),   32'(5));
        check("hs_data",   32'(mem_wdata),  32'(24'hABCDEF));
        check("hs_ren",    32'(mem_ren),    32'(0));
        advance();
        cpu_wvalid = 1'b0;
        tick(5);

        // Display line 0 while line 1 is fetched into bank 1.
        vga_valid = 1'b1; vga_v_addr = 10'd0;
        for (int h = 0; h < H; h++) begin
            vga_h_addr = 10'(h);
            sample();
            if (h == 1) check("line1_first_addr", 32'(mem_addr), 32'(640));
            if (h == 5) check("disp_px5", 32'(vga_data), 32'(24'h5A5DC3));
            advance();
        end
        vga_valid = 1'b0;
        sample();
        check("blank_data",      32'(vga_data), 32'(0));
        check("line1_last_addr", 32'(mem_addr), 32'(1279));
        advance();
        tick(20);

        // Line 1 display; a new line start 101 cycles in abandons the line-2 fetch.
        vga_valid = 1'b1; vga_v_addr = 10'd1;
        for (int h = 0; h < 100; h++) begin
            vga_h_addr = 10'(h);
            tick();
        end
        vga_valid = 1'b0;
        tick();
        vga_valid = 1'b1; vga_v_addr = 10'd2;
        for (int h = 0; h < H; h++) begin
            vga_h_addr = 10'(h);
            sample();
            if (h == 0) check("pre_underrun", 32'(underrun), 32'(0));
            if (h == 1) begin
                check("underrun_set", 32'(underrun), 32'(1));
                check("restart_addr", 32'(mem_addr), 32'(1920));
            end
            if (h == 100) check("inflight_capture", 32'(vga_data), 32'(24'h526AAE));
            advance();
        end
        vga_valid = 1'b0;
        tick(5);

        // Last visible line: no fetch, CPU writes flow every cycle.
        vga_valid = 1'b1; vga_v_addr = 10'd479; vga_h_addr = 10'd0;
        for (int i = 0; i < 8; i++) begin
            cpu_wvalid = 1'b1; cpu_waddr = 19'(200000 + i); cpu_wdata = 24'(24'h5000 + i);
            sample();
            if (i == 1) begin
                check("y479_busy", 32'(fetch_busy), 32'(0));
                check("y479_wen",  32'(mem_wen),    32'(1));
            end
            if (i == 7) check("y479_addr", 32'(mem_addr), 32'(200007));
            advance();
        end
        cpu_wvalid = 1'b0; vga_valid = 1'b0;
        tick(3);

        // Reset in the middle of a frame fetch.
        vga_vsync = 1'b0;
        tick(2);
        vga_vsync = 1'b1;
        tick(50);
        sample();
        check("pre_rst_busy", 32'(fetch_busy), 32'(1));
        advance();
        reset = 1'b1; vga_vsync = 1'b0;
        tick();
        reset = 1'b0;
        sample();
        check("post_rst_busy",     32'(fetch_busy), 32'(0));
        check("post_rst_ren",      32'(mem_ren),    32'(0));
        check("post_rst_underrun", 32'(underrun),   32'(0));
        check("post_rst_wready",   32'(cpu_wready), 32'(1));
        advance();
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
